// File: rtl/local_store_mem_pkg.sv
// Shared types and constant helpers for the local store: FSM state enum,
// address-split width functions and the response record carried down the read pipe.
package ls_pkg;

    // Response rdata is sized for the widest supported word; narrower builds
    // leave the upper bits constant zero so synthesis trims them away.
    localparam int LS_MAX_DATA_W = 1024;

    typedef enum logic {
        INIT,
        RUN
    } ls_state_e;

    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic                     valid;
        logic [LS_MAX_DATA_W-1:0] rdata;
        logic                     err;
        logic                     parity_err;
    } ls_rsp_t;

endpackage

// File: rtl/local_store_mem_resp_pipe.sv
// Response delay line: carries the response record through LAT registered
// stages, all cleared by the async active-low reset so in-flight responses vanish.
module ls_resp_pipe
    import ls_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  ls_rsp_t in_rsp,
    output ls_rsp_t out_rsp
);

    ls_rsp_t stage_q [LAT];
    ls_rsp_t stage_d [LAT];

    always_comb begin
        stage_d[0] = in_rsp;
        for (int i = 1; i < LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_rsp = stage_q[LAT-1];

endmodule

// File: rtl/local_store_mem.sv
// Quadword-addressed local store with byte-enable writes, post-reset clear sweep,
// range checking and an RD_LAT-deep response pipe. Optional per-byte parity: LS_PARITY_EN.
module local_store_mem
    import ls_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
`ifdef LS_PARITY_EN
    output logic              parity_err,
`endif
    output logic              init_done
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = off_w(DATA_W);
    localparam int IDX_W = idx_w(DEPTH);
    localparam int HI_W  = ADDR_W - OFF_W - IDX_W;

    ls_state_e          state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic               run_q, run_d;
    logic               clr_en;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [IDX_W-1:0]   word_idx;
    logic [DATA_W-1:0]  rd_word;
    logic               oor;
    logic               accept;
    logic               wr_en;
    logic               par_mismatch;

    ls_rsp_t            rsp_in, rsp_out;

    // INIT zeroes one word per cycle; ready is decoded from the next state so it
    // is a pure registered function of state and rises together with init_done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        case (state_q)
            INIT: begin
                clr_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
        run_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
        end
    end

    assign req_ready = run_q;
    assign init_done = run_q;

    assign word_idx = req_addr[OFF_W +: IDX_W];

    generate
        if (HI_W > 0) begin : g_range
            assign oor = |req_addr[ADDR_W-1:OFF_W+IDX_W];
        end else begin : g_no_range
            assign oor = 1'b0;
        end
        if (OFF_W > 0) begin : g_off
            logic unused_addr_off;
            assign unused_addr_off = ^req_addr[OFF_W-1:0];
        end
    endgenerate

    assign accept  = req_valid && run_q;
    assign wr_en   = accept && req_write && !oor;
    assign rd_word = mem_q[word_idx];

    // Array is not reset; the sweep owns clearing it after every reset.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (req_be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef LS_PARITY_EN
    logic [BYTES-1:0] par_q [DEPTH];
    logic [BYTES-1:0] wr_par;
    logic [BYTES-1:0] rd_par;

    always_comb begin
        wr_par = '0;
        rd_par = '0;
        for (int b = 0; b < BYTES; b++) begin
            wr_par[b] = ^req_wdata[8*b +: 8];
            rd_par[b] = ^rd_word[8*b +: 8];
        end
    end

    assign par_mismatch = |(rd_par ^ par_q[word_idx]);

    always_ff @(posedge clk) begin
        if (clr_en) begin
            par_q[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (req_be[b]) begin
                    par_q[word_idx][b] <= wr_par[b];
                end
            end
        end
    end
`else
    assign par_mismatch = 1'b0;
`endif

    // Stores and errored loads return zero data and never flag parity.
    always_comb begin
        rsp_in       = '0;
        rsp_in.valid = accept;
        rsp_in.err   = accept && oor;
        if (accept && !req_write && !oor) begin
            rsp_in.rdata[DATA_W-1:0] = rd_word;
            rsp_in.parity_err        = par_mismatch;
        end
    end

    ls_resp_pipe #(
        .LAT (RD_LAT)
    ) u_resp_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_rsp  (rsp_in),
        .out_rsp (rsp_out)
    );

    assign rsp_valid = rsp_out.valid;
    assign rsp_rdata = rsp_out.rdata[DATA_W-1:0];
    assign rsp_err   = rsp_out.err;

`ifdef LS_PARITY_EN
    assign parity_err = rsp_out.parity_err;
`else
    logic unused_parity;
    assign unused_parity = rsp_out.parity_err;
`endif

    generate
        if (DATA_W < LS_MAX_DATA_W) begin : g_rdata_hi
            logic unused_rdata_hi;
            assign unused_rdata_hi = ^rsp_out.rdata[LS_MAX_DATA_W-1:DATA_W];
        end
    endgenerate

endmodule
